// File: rtl/multicycle_controller.sv
// Multi-cycle control unit for the Simple-CPU RV32I core: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory handshakes, wait timeout, sticky trap and instret.
module multicycle_controller #(
   parameter int INST_WIDTH   = 32,
   parameter int ALUOP_WIDTH  = 3,
   parameter int ALUSRC_WIDTH = 2,
   parameter int TIMEOUT      = 16,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [INST_WIDTH-1:0]   inst,
   input  logic                    branch_taken,
   input  logic                    imem_ready,
   input  logic                    dmem_ready,
   output logic                    imem_req,
   output logic                    dmem_req,
   output logic                    ir_write,
   output logic                    pc_write,
   output logic [1:0]              pc_sel,
   output logic                    Branch,
   output logic [ALUOP_WIDTH-1:0]  ALUOp,
   output logic [ALUSRC_WIDTH-1:0] ALUSrc,
   output logic [ALUSRC_WIDTH-1:0] ALUSrc1,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    MemtoReg,
   output logic                    RegWrite,
   output logic                    trap,
   output logic [1:0]              trap_cause,
   output logic [CNT_WIDTH-1:0]    instret
);

   localparam int                WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM    = 2'd2;
   localparam logic [1:0] CAUSE_DMEM    = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic [1:0]             cause_q, cause_d;
   logic [CNT_WIDTH-1:0]   instret_q, instret_d;

   logic [6:0] opcode;
   logic [4:0] rd;
   logic       is_r, is_i, is_load, is_store, is_branch;
   logic       is_jal, is_jalr, is_lui, is_auipc, is_legal;
   logic       tmo_hit;
   logic       unused_inst_hi;

   logic [ALUOP_WIDTH-1:0]  aluop_dec;
   logic [ALUSRC_WIDTH-1:0] src2_dec;
   logic [ALUSRC_WIDTH-1:0] src1_dec;

   assign opcode         = inst[6:0];
   assign rd             = inst[11:7];
   assign unused_inst_hi = ^inst[INST_WIDTH-1:12];

   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                      is_jal | is_jalr | is_lui | is_auipc;

   // A ready seen while the counter sits at TIMEOUT is still accepted; only a low ready traps.
   assign tmo_hit = (TIMEOUT > 0) && (wait_q == WAIT_MAX);

   always_comb begin
      aluop_dec = ALUOP_WIDTH'(5);
      if (is_r)                        aluop_dec = ALUOP_WIDTH'(0);
      else if (is_i)                   aluop_dec = ALUOP_WIDTH'(1);
      else if (is_load || is_store)    aluop_dec = ALUOP_WIDTH'(2);
      else if (is_branch)              aluop_dec = ALUOP_WIDTH'(3);
      else if (is_jal || is_jalr)      aluop_dec = ALUOP_WIDTH'(4);

      src2_dec = ALUSRC_WIDTH'(2);
      if (is_r || is_branch)
         src2_dec = ALUSRC_WIDTH'(0);
      else if (is_i || is_load || is_store || is_lui || is_auipc)
         src2_dec = ALUSRC_WIDTH'(1);

      src1_dec = ALUSRC_WIDTH'(1);
      if (is_r || is_i || is_load || is_store || is_branch)
         src1_dec = ALUSRC_WIDTH'(0);
      else if (is_lui)
         src1_dec = ALUSRC_WIDTH'(2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         cause_q   <= 2'd0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      instret_d = instret_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
            end else if (tmo_hit) begin
               state_d = S_TRAP;
               cause_d = CAUSE_IMEM;
            end
         end
         S_DECODE: begin
            if (is_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            if (is_branch)                state_d = S_FETCH;
            else if (is_load || is_store) state_d = S_MEM;
            else                          state_d = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) begin
               state_d = is_load ? S_WB : S_FETCH;
            end else if (tmo_hit) begin
               state_d = S_TRAP;
               cause_d = CAUSE_DMEM;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase

      // Any state change (including entry to FETCH or MEM) restarts the wait count.
      if (state_d != state_q)
         wait_d = '0;
      else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
         wait_d = wait_q + WAIT_W'(1);
      else
         wait_d = wait_q;

      if (pc_write)
         instret_d = instret_q + CNT_WIDTH'(1);
   end

   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 2'd0;
      Branch     = 1'b0;
      ALUOp      = '0;
      ALUSrc     = '0;
      ALUSrc1    = '0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      trap       = 1'b0;
      trap_cause = 2'd0;
      instret    = '0;
      if (rst_n) begin
         instret    = instret_q;
         trap_cause = cause_q;
         if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            Branch  = is_branch | is_jal | is_jalr;
            ALUOp   = aluop_dec;
            ALUSrc  = src2_dec;
            ALUSrc1 = src1_dec;
         end
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
            end
            S_EXEC: begin
               if (is_branch) begin
                  pc_write = 1'b1;
                  pc_sel   = branch_taken ? 2'd1 : 2'd0;
               end
            end
            S_MEM: begin
               dmem_req = 1'b1;
               MemRead  = is_load;
               MemWrite = is_store;
               pc_write = is_store & dmem_ready;
            end
            S_WB: begin
               RegWrite = (rd != 5'd0);
               MemtoReg = is_load;
               pc_write = 1'b1;
               pc_sel   = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
            end
            S_TRAP:  trap = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: random instruction stream with random memory latencies,
// each instruction expanded into its expected per-cycle outputs and scored by a separate monitor.
`timescale 1ns/1ps
module tb_multicycle_controller;
   localparam int TMO = 16;
   localparam int CW  = 4;

   localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
   localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

   // strobe vector bit positions
   localparam int B_IREQ = 7, B_DREQ = 6, B_IRW = 5, B_PCW = 4;
   localparam int B_MRD = 3, B_MWR = 2, B_M2R = 1, B_RW = 0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   inst = '0;
   logic          branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic          imem_req, dmem_req, ir_write, pc_write;
   logic [1:0]    pc_sel;
   logic          Branch;
   logic [2:0]    ALUOp;
   logic [1:0]    ALUSrc, ALUSrc1;
   logic          MemRead, MemWrite, MemtoReg, RegWrite, trap;
   logic [1:0]    trap_cause;
   logic [CW-1:0] instret;

   multicycle_controller #(
      .INST_WIDTH(32), .ALUOP_WIDTH(3), .ALUSRC_WIDTH(2), .TIMEOUT(TMO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .branch_taken(branch_taken),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_sel(pc_sel), .Branch(Branch), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ALUSrc1(ALUSrc1),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .trap(trap), .trap_cause(trap_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         tag;
      logic          chk_sel;
      logic          chk_pc;
      logic [7:0]    strb;
      logic [1:0]    pc_sel;
      logic [7:0]    sel;      // {Branch, ALUOp, ALUSrc, ALUSrc1}
      logic          trap;
      logic [1:0]    cause;
      logic [CW-1:0] instret;
   } exp_t;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   retired = 0;

   function automatic int classify(input logic [6:0] op);
      case (op)
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LD;
         7'b0100011: return C_ST;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b1100111: return C_JALR;
         7'b0110111: return C_LUI;
         7'b0010111: return C_AUIPC;
         default:    return C_ILL;
      endcase
   endfunction

   function automatic logic [6:0] opcode_of(input int c);
      case (c)
         C_R:     return 7'b0110011;
         C_I:     return 7'b0010011;
         C_LD:    return 7'b0000011;
         C_ST:    return 7'b0100011;
         C_BR:    return 7'b1100011;
         C_JAL:   return 7'b1101111;
         C_JALR:  return 7'b1100111;
         C_LUI:   return 7'b0110111;
         default: return 7'b0010111;
      endcase
   endfunction

   // Select table: ALUOp R0 I1 LS2 BR3 J4 U5; ALUSrc REG0 IMM1 FOUR2; ALUSrc1 REG0 PC1 ZERO2.
   function automatic logic [7:0] sel_of(input int c);
      logic       br;
      logic [2:0] op;
      logic [1:0] s2, s1;
      br = (c == C_BR) || (c == C_JAL) || (c == C_JALR);
      case (c)
         C_R:          begin op = 3'd0; s2 = 2'd0; s1 = 2'd0; end
         C_I:          begin op = 3'd1; s2 = 2'd1; s1 = 2'd0; end
         C_LD, C_ST:   begin op = 3'd2; s2 = 2'd1; s1 = 2'd0; end
         C_BR:         begin op = 3'd3; s2 = 2'd0; s1 = 2'd0; end
         C_JAL, C_JALR:begin op = 3'd4; s2 = 2'd2; s1 = 2'd1; end
         C_LUI:        begin op = 3'd5; s2 = 2'd1; s1 = 2'd2; end
         C_AUIPC:      begin op = 3'd5; s2 = 2'd1; s1 = 2'd1; end
         default:      begin op = 3'd5; s2 = 2'd2; s1 = 2'd1; end
      endcase
      return {br, op, s2, s1};
   endfunction

   function automatic exp_t blank(input string tag);
      exp_t e;
      e.tag = tag; e.chk_sel = 1'b0; e.chk_pc = 1'b0; e.strb = '0; e.pc_sel = '0;
      e.sel = '0; e.trap = 1'b0; e.cause = '0; e.instret = '0;
      return e;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [31:0] mk(input int c, input logic rdz);
      logic [31:0] r;
      r = $urandom;
      r[6:0] = opcode_of(c);
      if (rdz) r[11:7] = 5'd0;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // One clock of stimulus; the expected outputs for that clock go to the scoreboard.
   task automatic cycle(input logic rn, input logic [31:0] ins, input logic bt,
                        input logic ir, input logic dr, input exp_t e);
      @(posedge clk);
      #1;
      rst_n = rn; inst = ins; branch_taken = bt; imem_ready = ir; dmem_ready = dr;
      if (!rn) retired = 0;
      e.instret = rn ? CW'(retired) : '0;
      exp_q.push_back(e);
      if (rn && e.strb[B_PCW]) retired++;
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e = blank("reset");
         e.chk_sel = 1'b1;
         e.chk_pc  = 1'b1;
         cycle(1'b0, $urandom, rb(), rb(), rb(), e);
      end
   endtask

   task automatic trap_tail(input logic [1:0] cause, input string nm);
      exp_t e;
      for (int i = 0; i < 20; i++) begin
         e = blank({nm, "/trap"});
         e.trap  = 1'b1;
         e.cause = cause;
         cycle(1'b1, $urandom, rb(), rb(), rb(), e);
      end
      do_reset(2);
   endtask

   // Expand one instruction into its cycle schedule: wi/wd are memory wait cycles before ready;
   // a wait longer than TMO traps on the first low-ready cycle after TMO waits have elapsed.
   task automatic run_instr(input logic [31:0] ins, input int wi, input int wd, input logic bt,
                            input int mem_rst_at, input string nm);
      int         c;
      logic [7:0] s;
      exp_t       e;
      c = classify(ins[6:0]);
      s = sel_of(c);
      for (int k = 0; k <= wi; k++) begin
         logic rdy;
         rdy = (k == wi);
         e = blank({nm, "/fetch"});
         e.strb[B_IREQ] = 1'b1;
         e.strb[B_IRW]  = rdy;
         cycle(1'b1, $urandom, rb(), rdy, rb(), e);
         if (!rdy && k == TMO) begin
            trap_tail(2'd2, nm);
            return;
         end
      end
      e = blank({nm, "/decode"});
      e.chk_sel = 1'b1; e.sel = s;
      cycle(1'b1, ins, rb(), rb(), rb(), e);
      if (c == C_ILL) begin
         trap_tail(2'd1, nm);
         return;
      end
      e = blank({nm, "/exec"});
      e.chk_sel = 1'b1; e.sel = s;
      if (c == C_BR) begin
         e.strb[B_PCW] = 1'b1; e.chk_pc = 1'b1; e.pc_sel = {1'b0, bt};
      end
      cycle(1'b1, ins, bt, rb(), rb(), e);
      if (c == C_BR) return;
      if (c == C_LD || c == C_ST) begin
         for (int k = 0; k <= wd; k++) begin
            logic rdy;
            rdy = (k == wd);
            if (k == mem_rst_at) return;
            e = blank({nm, "/mem"});
            e.chk_sel = 1'b1; e.sel = s;
            e.strb[B_DREQ] = 1'b1;
            e.strb[B_MRD]  = (c == C_LD);
            e.strb[B_MWR]  = (c == C_ST);
            if (c == C_ST && rdy) begin
               e.strb[B_PCW] = 1'b1; e.chk_pc = 1'b1; e.pc_sel = 2'd0;
            end
            cycle(1'b1, ins, rb(), rb(), rdy, e);
            if (!rdy && k == TMO) begin
               trap_tail(2'd3, nm);
               return;
            end
         end
         if (c == C_ST) return;
      end
      e = blank({nm, "/wb"});
      e.chk_sel = 1'b1; e.sel = s;
      e.strb[B_RW]  = (ins[11:7] != 5'd0);
      e.strb[B_M2R] = (c == C_LD);
      e.strb[B_PCW] = 1'b1;
      e.chk_pc = 1'b1;
      e.pc_sel = (c == C_JAL) ? 2'd1 : ((c == C_JALR) ? 2'd2 : 2'd0);
      cycle(1'b1, ins, rb(), rb(), rb(), e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.tag, " strobes"},
             {8'h0, imem_req, dmem_req, ir_write, pc_write, MemRead, MemWrite, MemtoReg, RegWrite},
             {8'h0, e.strb});
         chk({e.tag, " trap"}, {13'h0, trap, trap_cause}, {13'h0, e.trap, e.cause});
         chk({e.tag, " instret"}, {12'h0, instret}, {12'h0, e.instret});
         if (e.chk_pc)
            chk({e.tag, " pc_sel"}, {14'h0, pc_sel}, {14'h0, e.pc_sel});
         if (e.chk_sel)
            chk({e.tag, " selects"}, {8'h0, Branch, ALUOp, ALUSrc, ALUSrc1}, {8'h0, e.sel});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired act=running exp=finished");
      $fatal(1);
   end

   initial begin
      do_reset(3);
      run_instr(32'h00A00293, 0, 0, 1'b0, -1, "addi");
      run_instr(32'h0002A303, 0, 3, 1'b0, -1, "lw");
      run_instr(32'h00628463, 0, 0, 1'b1, -1, "beq_t");
      run_instr(32'h00628463, 0, 0, 1'b0, -1, "beq_nt");
      run_instr(32'h00000013, 0, 0, 1'b0, -1, "addi_x0");
      run_instr(32'h00A00293, TMO, 0, 1'b0, -1, "imem_edge");
      run_instr(32'h0002A303, 1, TMO, 1'b0, -1, "dmem_edge");

      for (int n = 0; n < 160; n++) begin
         int   c, wi, wd;
         logic rdz;
         c   = int'($urandom_range(0, 8));
         rdz = ($urandom_range(0, 5) == 0);
         wi  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, TMO)) : int'($urandom_range(0, 2));
         wd  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, TMO)) : int'($urandom_range(0, 2));
         run_instr(mk(c, rdz), wi, wd, rb(), -1, "rnd");
      end

      run_instr(32'h0002A303, 0, 10, 1'b0, 2, "lw_rst");
      do_reset(2);
      run_instr(32'h00A00293, 0, 0, 1'b0, -1, "post_rst");
      run_instr(32'h00000000, 0, 0, 1'b0, -1, "illegal0");
      run_instr(32'h0000000F, 1, 0, 1'b0, -1, "illegalF");
      run_instr(32'h00A00293, 40, 0, 1'b0, -1, "imem_tmo");
      run_instr(32'h0062A023, 0, 40, 1'b0, -1, "dmem_tmo");
      run_instr(32'h0062A023, 2, 1, 1'b0, -1, "sw");
      run_instr(32'h008000EF, 0, 0, 1'b0, -1, "jal");
      run_instr(32'h000280E7, 0, 0, 1'b0, -1, "jalr");

      @(negedge clk);
      #1;
      chk("queue drained", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control unit for the Simple-CPU RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK states, and produces the datapath selects (ALUOp, ALUSrc, ALUSrc1, MemtoReg, RegWrite, PC select). It adds ready/valid handshakes to instruction and data memory, a memory-wait timeout, a sticky trap, an rd=x0 write suppress and a retired-instruction counter. It sits between the instruction register and the register file, ALU, PC and memory ports.

## Interface
- INST_WIDTH, 32, instruction register width; opcode is inst[6:0] and rd is inst[11:7].
- ALUOP_WIDTH, 3, ALUOp width.
- ALUSRC_WIDTH, 2, ALUSrc and ALUSrc1 width.
- TIMEOUT, 16, maximum number of wait cycles on a memory handshake. 0 disables the timeout.
- CNT_WIDTH, 32, width of the instret counter.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, synchronous, active-low reset.
- inst, in, INST_WIDTH, instruction register contents. Held by the datapath after the ir_write pulse.
- branch_taken, in, 1, ALU compare result. Sampled in EXECUTE.
- imem_ready, in, 1, instruction memory has returned data this cycle.
- dmem_ready, in, 1, data memory has completed the access this cycle.
- imem_req, out, 1, instruction fetch request.
- dmem_req, out, 1, data access request.
- ir_write, out, 1, instruction register load strobe.
- pc_write, out, 1, PC update strobe.
- pc_sel, out, 2, next-PC select: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm.
- Branch, out, 1, current instruction is BRANCH, JAL or JALR.
- ALUOp, out, ALUOP_WIDTH, ALU operation class: R=0, I=1, LS=2, BRANCH=3, J=4, U=5.
- ALUSrc, out, ALUSRC_WIDTH, operand 2 select: REG=0, IMM=1, FOUR=2.
- ALUSrc1, out, ALUSRC_WIDTH, operand 1 select: REG=0, PC=1, ZERO=2.
- MemRead, out, 1, load access.
- MemWrite, out, 1, store access.
- MemtoReg, out, 1, write-back data comes from memory.
- RegWrite, out, 1, register file write strobe.
- trap, out, 1, sticky trap flag.
- trap_cause, out, 2, trap reason: 0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout.
- instret, out, CNT_WIDTH, count of retired instructions.

## Operation
**Reset and decode**
- rst_n=0 at a rising edge:
  - state goes to FETCH.
  - wait counter, instret, trap and trap_cause go to 0.
  - While rst_n=0, all outputs are forced to 0.
- Decoded selects come combinationally from inst. They are valid from DECODE until the instruction's final cycle.
- ALUOp by opcode:
  - R for 0110011; I for 0010011; LS for 0000011 and 0100011.
  - BRANCH for 1100011; J for 1101111 and 1100111; U otherwise.
- ALUSrc by opcode:
  - REG for R-type and branch.
  - IMM for arith-imm, load, store, LUI and AUIPC.
  - FOUR otherwise.
- ALUSrc1 by opcode:
  - REG for R-type, arith-imm, load, store and branch.
  - ZERO for LUI.
  - PC otherwise.

**State machine**
- FETCH: imem_req=1.
  - On imem_ready: ir_write=1 for that cycle, then go to DECODE.
- DECODE: one cycle.
  - Opcode not in the nine RV32I classes: go to TRAP with cause 1.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle. Branch output is valid here.
  - BRANCH: pc_write=1; pc_sel=1 if branch_taken, else 0; go to FETCH.
  - Load or store: go to MEM.
  - All others: go to WRITEBACK.
- MEM: dmem_req=1, with MemRead=1 for a load or MemWrite=1 for a store.
  - On dmem_ready, load: go to WRITEBACK.
  - On dmem_ready, store: pc_write=1, pc_sel=0, go to FETCH.
- WRITEBACK: one cycle.
  - RegWrite=1 unless rd==0.
  - MemtoReg=1 for a load.
  - pc_write=1; pc_sel=1 for JAL, 2 for JALR, 0 otherwise.
  - Go to FETCH.
- TRAP: all strobes are 0, trap=1, trap_cause is held. Only reset leaves TRAP.

**Wait counter and instret**
- Wait counter: cleared on entry to FETCH or MEM, incremented on each cycle that the request is held without ready.
- If TIMEOUT>0 and the counter reaches TIMEOUT with ready still low: go to TRAP with cause 2 (FETCH) or 3 (MEM).
- A ready arriving in the same cycle that the counter hits TIMEOUT wins: no trap.
- instret increments by 1 on every pc_write and wraps modulo 2^CNT_WIDTH.

## Timing
- All outputs are Moore, decoded from the registered state and inst. No input-to-state combinational loop except the ready-qualified strobes ir_write and pc_write.
- With zero-wait memory (ready in the same cycle as req), instruction latency in cycles:
  - Branch: 3.
  - Store: 4.
  - R-type, I-type, LUI, AUIPC, JAL, JALR: 4.
  - Load: 5.
- Each memory wait cycle adds one cycle.
- A request stays asserted until ready is sampled high. Requests are never withdrawn early.
- Exactly one pc_write per retired instruction, and it occurs in the instruction's last cycle.
- rst_n low in any state, including mid-MEM with dmem_req high: dmem_req drops in the same cycle, and FETCH follows after release.

## Test plan
- Reset, then addi x5 (0x00A00293) with imem_ready tied high:
  - Cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
  - In WRITEBACK: RegWrite=1, ALUOp=1, ALUSrc=1, pc_sel=0.
  - instret=1 after the WRITEBACK edge.
- lw (0x0002A303) with dmem_ready delayed 3 cycles: dmem_req and MemRead held for 4 cycles, MemtoReg=1 in WRITEBACK, total 8 cycles.
- beq (0x00628463):
  - branch_taken=1 → pc_sel=1 and pc_write in EXECUTE.
  - branch_taken=0 → pc_sel=0.
  - RegWrite is never 1 in either case.
- Opcode 0x00000000 → TRAP after DECODE with trap=1 and trap_cause=1. Strobes stay 0 for 20 cycles; only rst_n clears the trap.
- TIMEOUT=16 with imem_ready held low → trap_cause=2 after 16 wait cycles.
- Same setup but imem_ready=1 exactly on wait cycle 16 → no trap.
- addi x0 → RegWrite=0 and pc_write=1 in WRITEBACK.
- rst_n low during MEM → dmem_req=0 in the same cycle and instret=0.
